// File: rtl/larpix_fpga_uart.sv
// Serial link endpoint for the LArPix bench: one-bit-per-clock UART TX driving posi and RX capturing piso.
// A frame is a start bit, WIDTH data bits LSB first (top bit is odd parity), then a stop bit.
module larpix_fpga_uart #(
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_ld_tx_data,
  input  logic             i_tx_enable,
  input  logic             i_enable_tx_dynamic_powerdown,
  input  logic [2:0]       i_tx_dynamic_powerdown_cycles,
  output logic             o_tx_out,
  output logic             o_tx_busy,
  output logic             o_tx_powerdown,
  input  logic             i_rx_in,
  input  logic             i_uld_rx_data,
  input  logic             i_v3_mode,
  output logic [WIDTH-2:0] o_rx_data,
  output logic             o_rx_empty,
  output logic             o_parity_error
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_DATA  = 2'd1;
  localparam logic [1:0] RX_STOP  = 2'd2;

  // Odd parity over the whole frame: an even count of ones is an error.
  function automatic logic odd_parity_error(input logic [WIDTH-1:0] frame);
    return ~(^frame);
  endfunction

  // ---------------- TX ----------------
  logic [1:0]       r_tx_state;
  logic [WIDTH-1:0] r_tx_shift;
  logic [CW-1:0]    r_tx_cnt;
  logic             r_tx_out;
  logic             r_tx_busy;
  logic [7:0]       r_idle_cnt;
  logic             r_tx_powerdown;

  logic [1:0]       w_tx_state_nxt;
  logic [WIDTH-1:0] w_tx_shift_nxt;
  logic [CW-1:0]    w_tx_cnt_nxt;
  logic             w_tx_out_nxt;
  logic             w_tx_busy_nxt;
  logic             w_tx_accept;
  logic [3:0]       w_pd_mult;
  logic [7:0]       w_pd_thr;
  logic [7:0]       w_idle_cnt_nxt;
  logic             w_tx_powerdown_nxt;

  // Loads are taken in IDLE, or in STOP so consecutive frames abut with no gap.
  assign w_tx_accept = i_ld_tx_data & i_tx_enable &
                       ((r_tx_state == TX_IDLE) | (r_tx_state == TX_STOP));

  assign w_pd_mult = {1'b0, i_tx_dynamic_powerdown_cycles} + 4'd1;
  assign w_pd_thr  = {w_pd_mult, 4'd0};

  // TX next-state: the registered line value always reflects the bit of the current state.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_out_nxt   = r_tx_out;
    w_tx_busy_nxt  = r_tx_busy;
    case (r_tx_state)
      TX_IDLE, TX_STOP: begin
        if (w_tx_accept) begin
          w_tx_shift_nxt = i_tx_data;
          w_tx_cnt_nxt   = {CW{1'b0}};
          w_tx_out_nxt   = 1'b0;
          w_tx_busy_nxt  = 1'b1;
          w_tx_state_nxt = TX_START;
        end else begin
          w_tx_out_nxt   = 1'b1;
          w_tx_busy_nxt  = 1'b0;
          w_tx_state_nxt = TX_IDLE;
        end
      end
      TX_START: begin
        w_tx_out_nxt   = r_tx_shift[0];
        w_tx_shift_nxt = {1'b0, r_tx_shift[WIDTH-1:1]};
        w_tx_cnt_nxt   = {CW{1'b0}};
        w_tx_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        if (r_tx_cnt == LAST_BIT) begin
          w_tx_out_nxt   = 1'b1;
          w_tx_state_nxt = TX_STOP;
        end else begin
          w_tx_out_nxt   = r_tx_shift[0];
          w_tx_shift_nxt = {1'b0, r_tx_shift[WIDTH-1:1]};
          w_tx_cnt_nxt   = r_tx_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_tx_out_nxt   = 1'b1;
        w_tx_busy_nxt  = 1'b0;
        w_tx_state_nxt = TX_IDLE;
      end
    endcase
  end

  // Idle counter saturates at the threshold; the indicator rises on the edge it gets there.
  always_comb begin
    w_idle_cnt_nxt     = r_idle_cnt;
    w_tx_powerdown_nxt = r_tx_powerdown;
    if (w_tx_accept || !i_enable_tx_dynamic_powerdown) begin
      w_idle_cnt_nxt     = 8'd0;
      w_tx_powerdown_nxt = 1'b0;
    end else if (r_tx_state == TX_IDLE) begin
      w_idle_cnt_nxt     = (r_idle_cnt < w_pd_thr) ? (r_idle_cnt + 8'd1) : r_idle_cnt;
      w_tx_powerdown_nxt = (w_idle_cnt_nxt >= w_pd_thr);
    end else begin
      w_idle_cnt_nxt     = 8'd0;
      w_tx_powerdown_nxt = 1'b0;
    end
  end

  // TX registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_state     <= TX_IDLE;
      r_tx_shift     <= {WIDTH{1'b0}};
      r_tx_cnt       <= {CW{1'b0}};
      r_tx_out       <= 1'b1;
      r_tx_busy      <= 1'b0;
      r_idle_cnt     <= 8'd0;
      r_tx_powerdown <= 1'b0;
    end else begin
      r_tx_state     <= w_tx_state_nxt;
      r_tx_shift     <= w_tx_shift_nxt;
      r_tx_cnt       <= w_tx_cnt_nxt;
      r_tx_out       <= w_tx_out_nxt;
      r_tx_busy      <= w_tx_busy_nxt;
      r_idle_cnt     <= w_idle_cnt_nxt;
      r_tx_powerdown <= w_tx_powerdown_nxt;
    end
  end

  assign o_tx_out       = r_tx_out;
  assign o_tx_busy      = r_tx_busy;
  assign o_tx_powerdown = r_tx_powerdown;

  // ---------------- RX ----------------
  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_rx_state;
  logic [WIDTH-1:0] r_rx_shift;
  logic [CW-1:0]    r_rx_cnt;
  logic             r_rx_armed;
  logic [WIDTH-2:0] r_rx_data;
  logic             r_rx_empty;
  logic             r_parity_error;

  logic             w_rx_bit;
  logic [1:0]       w_rx_state_nxt;
  logic [WIDTH-1:0] w_rx_shift_nxt;
  logic [CW-1:0]    w_rx_cnt_nxt;
  logic             w_rx_armed_nxt;
  logic             w_rx_accept;
  logic [WIDTH-2:0] w_rx_data_nxt;
  logic             w_rx_empty_nxt;
  logic             w_parity_error_nxt;

  assign w_rx_bit = r_sync2;

  // RX next-state; after a bad stop bit the receiver is disarmed until the line returns high.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_armed_nxt = r_rx_armed;
    w_rx_accept    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_armed && !w_rx_bit) begin
          w_rx_cnt_nxt   = {CW{1'b0}};
          w_rx_state_nxt = RX_DATA;
        end else if (w_rx_bit) begin
          w_rx_armed_nxt = 1'b1;
        end else begin
          w_rx_armed_nxt = r_rx_armed;
        end
      end
      RX_DATA: begin
        w_rx_shift_nxt = {w_rx_bit, r_rx_shift[WIDTH-1:1]};
        if (r_rx_cnt == LAST_BIT) begin
          w_rx_state_nxt = RX_STOP;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      RX_STOP: begin
        w_rx_state_nxt = RX_IDLE;
        if (w_rx_bit) begin
          w_rx_accept = 1'b1;
        end else begin
          w_rx_armed_nxt = 1'b0;
        end
      end
      default: begin
        w_rx_state_nxt = RX_IDLE;
      end
    endcase
  end

  // Accept beats a simultaneous unload so a fresh frame is never lost.
  always_comb begin
    w_rx_data_nxt      = r_rx_data;
    w_rx_empty_nxt     = r_rx_empty;
    w_parity_error_nxt = r_parity_error;
    if (w_rx_accept) begin
      w_rx_data_nxt      = r_rx_shift[WIDTH-2:0];
      w_parity_error_nxt = i_v3_mode ? odd_parity_error(r_rx_shift) : 1'b0;
      w_rx_empty_nxt     = 1'b0;
    end else if (i_uld_rx_data && !r_rx_empty) begin
      w_rx_empty_nxt = 1'b1;
    end else begin
      w_rx_empty_nxt = r_rx_empty;
    end
  end

  // RX registers, including the input synchronizer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1        <= 1'b1;
      r_sync2        <= 1'b1;
      r_rx_state     <= RX_IDLE;
      r_rx_shift     <= {WIDTH{1'b0}};
      r_rx_cnt       <= {CW{1'b0}};
      r_rx_armed     <= 1'b1;
      r_rx_data      <= {(WIDTH-1){1'b0}};
      r_rx_empty     <= 1'b1;
      r_parity_error <= 1'b0;
    end else begin
      r_sync1        <= i_rx_in;
      r_sync2        <= r_sync1;
      r_rx_state     <= w_rx_state_nxt;
      r_rx_shift     <= w_rx_shift_nxt;
      r_rx_cnt       <= w_rx_cnt_nxt;
      r_rx_armed     <= w_rx_armed_nxt;
      r_rx_data      <= w_rx_data_nxt;
      r_rx_empty     <= w_rx_empty_nxt;
      r_parity_error <= w_parity_error_nxt;
    end
  end

  assign o_rx_data      = r_rx_data;
  assign o_rx_empty     = r_rx_empty;
  assign o_parity_error = r_parity_error;

endmodule

// File: tb/tb_larpix_fpga_uart.sv
// Self-checking bench for larpix_fpga_uart: loopback scoreboard plus direct TX/RX scenarios.
module tb_larpix_fpga_uart;

  localparam int WIDTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] tx_data;
  logic        ld_tx_data;
  logic        tx_enable;
  logic        en_pd;
  logic [2:0]  pd_cycles;
  logic        tx_out;
  logic        tx_busy;
  logic        tx_powerdown;
  logic        rx_in;
  logic        uld_rx_data;
  logic        v3_mode;
  logic [62:0] rx_data;
  logic        rx_empty;
  logic        parity_error;

  logic        loopback;
  logic        rx_drive;

  int total = 0;
  int bad   = 0;

  logic [62:0] exp_data_q[$];
  logic        exp_perr_q[$];

  assign rx_in = loopback ? tx_out : rx_drive;

  always #5 clk = ~clk;

  larpix_fpga_uart #(.WIDTH(WIDTH)) dut (
    .i_clk                         (clk),
    .i_reset                       (reset),
    .i_tx_data                     (tx_data),
    .i_ld_tx_data                  (ld_tx_data),
    .i_tx_enable                   (tx_enable),
    .i_enable_tx_dynamic_powerdown (en_pd),
    .i_tx_dynamic_powerdown_cycles (pd_cycles),
    .o_tx_out                      (tx_out),
    .o_tx_busy                     (tx_busy),
    .o_tx_powerdown                (tx_powerdown),
    .i_rx_in                       (rx_in),
    .i_uld_rx_data                 (uld_rx_data),
    .i_v3_mode                     (v3_mode),
    .o_rx_data                     (rx_data),
    .o_rx_empty                    (rx_empty),
    .o_parity_error                (parity_error)
  );

  // All tasks start and end just after a falling edge.
  task automatic exp_push(input logic [62:0] d, input logic p);
    exp_data_q.push_back(d);
    exp_perr_q.push_back(p);
  endtask

  task automatic load_tx(input logic [63:0] d);
    tx_data    = d;
    ld_tx_data = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld_tx_data = 1'b0;
  endtask

  task automatic unload();
    uld_rx_data = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    uld_rx_data = 1'b0;
  endtask

  task automatic wait_rx(output logic ok);
    int n;
    n = 0;
    while (rx_empty && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = !rx_empty;
  endtask

  task automatic drive_frame(input logic [63:0] d, input logic stop);
    rx_drive = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      rx_drive = d[i];
      @(negedge clk);
    end
    rx_drive = stop;
    @(negedge clk);
    rx_drive = 1'b1;
  endtask

  task automatic test_reset();
    loopback = 1'b0;
    rx_drive = 1'b1;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL reset_tx_out: got %b expected 1", tx_out); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
    total++; if (tx_powerdown !== 1'b0) begin bad++; $display("FAIL reset_tx_powerdown: got %b expected 0", tx_powerdown); end
    total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL reset_rx_empty: got %b expected 1", rx_empty); end
    total++; if (rx_data !== 63'h0) begin bad++; $display("FAIL reset_rx_data: got %h expected 0", rx_data); end
    total++; if (parity_error !== 1'b0) begin bad++; $display("FAIL reset_parity_error: got %b expected 0", parity_error); end
    loopback = 1'b1;
  endtask

  task automatic test_loopback();
    logic ok;
    logic [62:0] ed;
    logic ep;
    v3_mode = 1'b1;
    load_tx(64'h0000_0000_0000_0002);
    exp_push(63'h0000_0000_0000_0002, 1'b0);
    wait_rx(ok);
    total++; if (!ok) begin bad++; $display("FAIL loop_arrival: rx_empty=%b expected 0", rx_empty); end
    ed = exp_data_q.pop_front();
    ep = exp_perr_q.pop_front();
    total++; if (rx_data !== ed) begin bad++; $display("FAIL loop_data: got %h expected %h", rx_data, ed); end
    total++; if (parity_error !== ep) begin bad++; $display("FAIL loop_parity: got %b expected %b", parity_error, ep); end
    unload();
    total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL unload_empty: got %b expected 1", rx_empty); end
    total++; if (rx_data !== ed) begin bad++; $display("FAIL unload_data_held: got %h expected %h", rx_data, ed); end
  endtask

  task automatic test_parity();
    logic ok;
    logic [62:0] ed;
    logic ep;
    for (int m = 0; m < 2; m++) begin
      v3_mode = (m == 0) ? 1'b1 : 1'b0;
      load_tx(64'h8000_0000_0000_0002);
      exp_push(63'h0000_0000_0000_0002, (m == 0) ? 1'b1 : 1'b0);
      wait_rx(ok);
      total++; if (!ok) begin bad++; $display("FAIL parity_arrival_%0d: rx_empty=%b expected 0", m, rx_empty); end
      ed = exp_data_q.pop_front();
      ep = exp_perr_q.pop_front();
      total++; if (rx_data !== ed) begin bad++; $display("FAIL parity_data_%0d: got %h expected %h", m, rx_data, ed); end
      total++; if (parity_error !== ep) begin bad++; $display("FAIL parity_flag_%0d: got %b expected %b", m, parity_error, ep); end
      unload();
    end
    v3_mode = 1'b1;
  endtask

  task automatic test_tx_timing();
    logic ok;
    logic [62:0] ed;
    logic ep;
    logic [63:0] d;
    logic exp_bits[66];
    int busy_cnt;
    tx_enable = 1'b0;
    load_tx(64'h0000_0000_0000_00A5);
    total++; if (tx_busy !== 1'b0 || tx_out !== 1'b1) begin bad++; $display("FAIL tx_disabled: busy=%b out=%b expected 0/1", tx_busy, tx_out); end
    tx_enable = 1'b1;
    @(negedge clk);
    d = 64'h0000_0000_0000_00A5;
    exp_bits[0] = 1'b0;
    for (int j = 0; j < 64; j++) exp_bits[j+1] = d[j];
    exp_bits[65] = 1'b1;
    load_tx(d);
    exp_push(63'h0000_0000_0000_00A5, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      if (i < 66) begin
        total++;
        if (tx_out !== exp_bits[i]) begin bad++; $display("FAIL tx_bit_%0d: got %b expected %b", i, tx_out, exp_bits[i]); end
      end
      if (tx_busy === 1'b1) busy_cnt++;
      if (i == 10) begin
        tx_data    = 64'hFFFF_FFFF_FFFF_FFFF;
        ld_tx_data = 1'b1;
      end
      if (i == 11) ld_tx_data = 1'b0;
      @(negedge clk);
    end
    total++; if (busy_cnt != 66) begin bad++; $display("FAIL tx_busy_len: got %0d expected 66", busy_cnt); end
    wait_rx(ok);
    total++; if (!ok) begin bad++; $display("FAIL tx_rx_arrival: rx_empty=%b expected 0", rx_empty); end
    ed = exp_data_q.pop_front();
    ep = exp_perr_q.pop_front();
    total++; if (rx_data !== ed) begin bad++; $display("FAIL tx_rx_data: got %h expected %h", rx_data, ed); end
    total++; if (parity_error !== ep) begin bad++; $display("FAIL tx_rx_parity: got %b expected %b", parity_error, ep); end
    unload();
  endtask

  task automatic test_back_to_back();
    logic ok;
    logic [62:0] ed;
    logic ep;
    load_tx(64'h0123_4567_89AB_CDEF);
    exp_push(63'h0123_4567_89AB_CDEF, 1'b1);
    repeat (65) @(negedge clk);
    load_tx(64'h7EDC_BA98_7654_3210);
    exp_push(63'h7EDC_BA98_7654_3210, 1'b0);
    total++; if (tx_busy !== 1'b1 || tx_out !== 1'b0) begin bad++; $display("FAIL b2b_start: busy=%b out=%b expected 1/0", tx_busy, tx_out); end
    wait_rx(ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_arrival: rx_empty=%b expected 0", rx_empty); end
    ed = exp_data_q.pop_front();
    ep = exp_perr_q.pop_front();
    total++; if (rx_data !== ed) begin bad++; $display("FAIL b2b_first_data: got %h expected %h", rx_data, ed); end
    total++; if (parity_error !== ep) begin bad++; $display("FAIL b2b_first_parity: got %b expected %b", parity_error, ep); end
    repeat (66) @(negedge clk);
    ed = exp_data_q.pop_front();
    ep = exp_perr_q.pop_front();
    total++; if (rx_empty !== 1'b0) begin bad++; $display("FAIL b2b_overrun_empty: got %b expected 0", rx_empty); end
    total++; if (rx_data !== ed) begin bad++; $display("FAIL b2b_second_data: got %h expected %h", rx_data, ed); end
    total++; if (parity_error !== ep) begin bad++; $display("FAIL b2b_second_parity: got %b expected %b", parity_error, ep); end
    unload();
  endtask

  task automatic test_framing();
    logic ok;
    logic [62:0] ed;
    logic ep;
    loopback = 1'b0;
    rx_drive = 1'b1;
    @(negedge clk);
    drive_frame(64'hDEAD_BEEF_0000_0001, 1'b0);
    repeat (10) @(negedge clk);
    total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL framing_empty: got %b expected 1", rx_empty); end
    total++; if (rx_data !== 63'h7EDC_BA98_7654_3210) begin bad++; $display("FAIL framing_data_held: got %h expected 7edcba9876543210", rx_data); end
    drive_frame(64'h0000_0000_0000_0007, 1'b1);
    exp_push(63'h0000_0000_0000_0007, 1'b0);
    wait_rx(ok);
    total++; if (!ok) begin bad++; $display("FAIL framing_recover_arrival: rx_empty=%b expected 0", rx_empty); end
    ed = exp_data_q.pop_front();
    ep = exp_perr_q.pop_front();
    total++; if (rx_data !== ed) begin bad++; $display("FAIL framing_recover_data: got %h expected %h", rx_data, ed); end
    total++; if (parity_error !== ep) begin bad++; $display("FAIL framing_recover_parity: got %b expected %b", parity_error, ep); end
    unload();
  endtask

  task automatic test_powerdown();
    loopback  = 1'b0;
    rx_drive  = 1'b1;
    pd_cycles = 3'd1;
    en_pd     = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (tx_powerdown !== 1'b0) begin bad++; $display("FAIL pd_early: got %b expected 0", tx_powerdown); end
    repeat (20) @(negedge clk);
    total++; if (tx_powerdown !== 1'b1) begin bad++; $display("FAIL pd_set: got %b expected 1", tx_powerdown); end
    load_tx(64'h0000_0000_0000_0001);
    total++; if (tx_powerdown !== 1'b0) begin bad++; $display("FAIL pd_clear_on_load: got %b expected 0", tx_powerdown); end
    repeat (70) @(negedge clk);
    en_pd = 1'b0;
    repeat (40) @(negedge clk);
    total++; if (tx_powerdown !== 1'b0) begin bad++; $display("FAIL pd_disabled: got %b expected 0", tx_powerdown); end
  endtask

  task automatic test_reset_mid_tx();
    loopback = 1'b0;
    rx_drive = 1'b1;
    load_tx(64'h0000_0000_0000_0000);
    repeat (10) @(negedge clk);
    total++; if (tx_busy !== 1'b1 || tx_out !== 1'b0) begin bad++; $display("FAIL midtx_inflight: busy=%b out=%b expected 1/0", tx_busy, tx_out); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL midtx_reset_out: got %b expected 1", tx_out); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL midtx_reset_busy: got %b expected 0", tx_busy); end
    total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL midtx_reset_rx_empty: got %b expected 1", rx_empty); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    tx_data     = 64'h0;
    ld_tx_data  = 1'b0;
    tx_enable   = 1'b1;
    en_pd       = 1'b0;
    pd_cycles   = 3'd0;
    uld_rx_data = 1'b0;
    v3_mode     = 1'b1;
    loopback    = 1'b0;
    rx_drive    = 1'b1;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_parity();
    test_tx_timing();
    test_back_to_back();
    test_framing();
    test_powerdown();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
